// File: rtl/aes_cipher.sv
// ---------------------------------------------------------------------------
// aes_cipher
//   Iterative AES forward cipher. One round per enabled clock; a block takes
//   NR+1 enabled clocks (initial AddRoundKey + NR rounds). The state after each
//   round is registered on roundOut so it can be displayed, checked, and the
//   final ciphertext handed to the inverse cipher.
//
// Parameters
//   NK  key length in 32-bit words (4/6/8); must satisfy NR == NK+6
//   NR  number of rounds (10/12/14)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   enable     1 = advance one round per clock, 0 = hold all state
//   plainText  input block, bits[0:7] = byte 0; sampled only in round 0
//   keys       flattened round keys, bits[128*r +: 128] = round key r
//   roundOut   registered state after the most recent round
//   done       set once the final round has been applied; sticky until reset
//   roundIdx   (only with AES_CIPHER_DBG_EN) current round counter
//
// Configuration
//   AES_CIPHER_DBG_EN  adds the roundIdx debug output
// ---------------------------------------------------------------------------
module aes_cipher #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [0:127]          plainText,
   input  logic [0:128*(NR+1)-1] keys,
   output logic [0:127]          roundOut,
   output logic                  done
`ifdef AES_CIPHER_DBG_EN
   ,
   output logic [4:0]            roundIdx
`endif
);

   if (NR != NK + 6) begin : g_cfg_err
      $error("aes_cipher: NR must equal NK+6");
   end

   // S-box, entry x at bits [8x +: 8]
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   logic [0:127] round_q, round_d;
   logic [4:0]   rc_q, rc_d;
   logic         done_q, done_d;

   logic [0:127] rk;
   logic [0:127] sr_v;
   logic [0:127] mc_v;
   logic [7:0]   sb [16];

   // Round datapath: key select, SubBytes, ShiftRows, MixColumns
   always_comb begin
      rk   = '0;
      sr_v = '0;
      mc_v = '0;
      for (int unsigned r = 0; r <= unsigned'(NR); r++) begin
         if (rc_q == 5'(r)) rk = keys[128*r +: 128];
      end
      for (int unsigned i = 0; i < 16; i++) begin
         sb[i] = sbox(round_q[8*i +: 8]);
      end
      // byte 4c+r of the output comes from column (c+r) mod 4 of the same row
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr_v[8*(4*c+r) +: 8] = sb[4*((c+r)%4) + r];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         mc_v[32*c +: 32] = mix_col(sr_v[32*c +: 32]);
      end
   end

   // Round sequencing; done is sticky, so nothing advances once set
   always_comb begin
      round_d = round_q;
      rc_d    = rc_q;
      done_d  = done_q;
      if (enable && !done_q) begin
         rc_d = rc_q + 5'd1;
         if (rc_q == 5'd0) begin
            round_d = plainText ^ rk;
         end else if (rc_q == 5'(NR)) begin
            round_d = sr_v ^ rk;
            done_d  = 1'b1;
         end else begin
            round_d = mc_v ^ rk;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         round_q <= '0;
         rc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         round_q <= round_d;
         rc_q    <= rc_d;
         done_q  <= done_d;
      end
   end

   assign roundOut = round_q;
   assign done     = done_q;
`ifdef AES_CIPHER_DBG_EN
   assign roundIdx = rc_q;
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher
//   Directed bench for aes_cipher with NR=10/12/14 instances. Round keys are
//   produced by a local key expansion whose S-box is derived arithmetically
//   (GF inverse + affine map); expected states are the FIPS-197 vectors.
// ---------------------------------------------------------------------------
module tb_aes_cipher;

   localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] R1    = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] R2    = 128'h89d810e8855ace682d1843d8cb128fe4;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [0:127] pt;
   logic [0:1919] ks10, ks12, ks14;

   logic [0:127] ro10, ro12, ro14;
   logic         d10, d12, d14;
`ifdef AES_CIPHER_DBG_EN
   logic [4:0]   ri10, ri12, ri14;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_cipher #(.NK(4), .NR(10)) u10 (
      .clk(clk), .reset(reset), .enable(enable), .plainText(pt),
      .keys(ks10[0:1407]), .roundOut(ro10), .done(d10)
`ifdef AES_CIPHER_DBG_EN
      , .roundIdx(ri10)
`endif
   );
   aes_cipher #(.NK(6), .NR(12)) u12 (
      .clk(clk), .reset(reset), .enable(enable), .plainText(pt),
      .keys(ks12[0:1663]), .roundOut(ro12), .done(d12)
`ifdef AES_CIPHER_DBG_EN
      , .roundIdx(ri12)
`endif
   );
   aes_cipher #(.NK(8), .NR(14)) u14 (
      .clk(clk), .reset(reset), .enable(enable), .plainText(pt),
      .keys(ks14), .roundOut(ro14), .done(d14)
`ifdef AES_CIPHER_DBG_EN
      , .roundIdx(ri14)
`endif
   );

   // ---------------- reference helpers ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] sb_m(input logic [7:0] x);
      logic [7:0] v;
      v = '0;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb_m(w[31:24]), sb_m(w[23:16]), sb_m(w[15:8]), sb_m(w[7:0])};
   endfunction

   function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [0:1919] o;
      rcon = 8'h01;
      o    = '0;
      for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nk+7); i++) o[32*i +: 32] = w[i];
      return o;
   endfunction

   // ---------------- checking / driving ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      enable = 1'b0;
      reset  = 1'b0;
      pt     = PT;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // n enabled rising edges; returns 1 time unit after the last edge
   task automatic run(input int n);
      if (n > 0) begin
         enable = 1'b1;
         repeat (n) @(posedge clk);
         #1 enable = 1'b0;
      end
   endtask

   task automatic hold(input int n);
      enable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int           dut;
      int           nclk;
      logic         chk_data;
      logic [127:0] exp_ro;
      logic         exp_done;
   } vec_t;

   vec_t         vt [9];
   logic [127:0] act_ro;
   logic         act_d;
`ifdef AES_CIPHER_DBG_EN
   logic [4:0]   act_ri;
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      pt     = PT;
      ks10 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
      ks12 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
      ks14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

      vt[0] = '{0,  0, 1'b1, 128'h0, 1'b0};
      vt[1] = '{0,  1, 1'b1, R1,     1'b0};
      vt[2] = '{0,  2, 1'b1, R2,     1'b0};
      vt[3] = '{0, 10, 1'b0, 128'h0, 1'b0};
      vt[4] = '{0, 11, 1'b1, CT128,  1'b1};
      vt[5] = '{1, 12, 1'b0, 128'h0, 1'b0};
      vt[6] = '{1, 13, 1'b1, CT192,  1'b1};
      vt[7] = '{2, 14, 1'b0, 128'h0, 1'b0};
      vt[8] = '{2, 15, 1'b1, CT256,  1'b1};

      for (int i = 0; i < 9; i++) begin
         do_reset();
         run(vt[i].nclk);
         case (vt[i].dut)
            0:       begin act_ro = ro10; act_d = d10; end
            1:       begin act_ro = ro12; act_d = d12; end
            default: begin act_ro = ro14; act_d = d14; end
         endcase
         if (vt[i].chk_data) chk($sformatf("vec%0d_roundOut", i), act_ro, vt[i].exp_ro);
         chk($sformatf("vec%0d_done", i), 128'(act_d), 128'(vt[i].exp_done));
`ifdef AES_CIPHER_DBG_EN
         case (vt[i].dut)
            0:       act_ri = ri10;
            1:       act_ri = ri12;
            default: act_ri = ri14;
         endcase
         chk($sformatf("vec%0d_roundIdx", i), 128'(act_ri), 128'(vt[i].nclk));
`endif
      end

      // Pause after round 2 with plainText changed mid-block: state frozen, result unaffected
      do_reset();
      run(2);
      pt = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
      chk("pause2_before", ro10, R2);
      hold(3);
      chk("pause2_frozen", ro10, R2);
      chk("pause2_done", 128'(d10), 128'd0);
      run(9);
      chk("pause2_ct", ro10, CT128);
      chk("pause2_done_end", 128'(d10), 128'd1);

      // Pause for 3 clocks after clk4: ciphertext at the 14th clock overall
      do_reset();
      run(4);
      hold(3);
`ifdef AES_CIPHER_DBG_EN
      chk("pause4_roundIdx", 128'(ri10), 128'd4);
`endif
      run(6);
      chk("pause4_done_at13", 128'(d10), 128'd0);
      run(1);
      chk("pause4_ct_at14", ro10, CT128);
      chk("pause4_done_at14", 128'(d10), 128'd1);

      // Asynchronous reset mid-cycle during round 5, then a clean re-run
      do_reset();
      run(4);
      enable = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("areset_roundOut", ro10, 128'h0);
      chk("areset_done", 128'(d10), 128'd0);
`ifdef AES_CIPHER_DBG_EN
      chk("areset_roundIdx", 128'(ri10), 128'd0);
`endif
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run(10);
      chk("rerun_done_at10", 128'(d10), 128'd0);
      run(1);
      chk("rerun_ct", ro10, CT128);
      chk("rerun_done", 128'(d10), 128'd1);

      // After done: enable held high, plainText changing, output must not move
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         chk($sformatf("post_done_ct%0d", k), ro10, CT128);
         chk($sformatf("post_done_flag%0d", k), 128'(d10), 128'd1);
      end
`ifdef AES_CIPHER_DBG_EN
      chk("post_done_roundIdx", 128'(ri10), 128'd11);
`endif
      enable = 1'b0;
      pt     = PT;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
